// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between requesters A and B.
// Ports: clk/rst_n; A and B request (valid/ready) and response (valid/ready)
// handshakes; alu_in1/alu_in2/alu_op to the ALU, alu_out from it; busy.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_in1,
    input  logic [WIDTH-1:0] a_in2,
    input  logic [OP_W-1:0]  a_op,
    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic [WIDTH-1:0] a_rsp_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_in1,
    input  logic [WIDTH-1:0] b_in2,
    input  logic [OP_W-1:0]  b_op,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [WIDTH-1:0] b_rsp_data,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             last_b;
    logic             owner_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] b_hold;
    logic             grant_a;
    logic             grant_b;
    logic             accept;
    logic             rsp_fire;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_a = a_valid & (~b_valid | last_b);
        grant_b = b_valid & (~a_valid | ~last_b);
    end

    assign a_ready  = (state == IDLE) & grant_a;
    assign b_ready  = (state == IDLE) & grant_b;
    assign accept   = a_ready | b_ready;
    assign rsp_fire = (state == RESP) &
                      (owner_b ? b_rsp_ready : a_rsp_ready);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // While responding the live result is shown; afterwards the
    // requester keeps seeing its own last result.
    always_comb begin
        a_rsp_valid = (state == RESP) & ~owner_b;
        b_rsp_valid = (state == RESP) & owner_b;
        a_rsp_data  = a_rsp_valid ? result : a_hold;
        b_rsp_data  = b_rsp_valid ? result : b_hold;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            owner_b <= 1'b0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_op  <= '0;
            result  <= '0;
            a_hold  <= '0;
            b_hold  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                owner_b <= b_ready;
                alu_in1 <= b_ready ? b_in1 : a_in1;
                alu_in2 <= b_ready ? b_in2 : a_in2;
                alu_op  <= b_ready ? b_op  : a_op;
            end
            if (state == EXEC) begin
                result <= alu_out;
            end
            if (rsp_fire) begin
                last_b <= owner_b;
                if (owner_b) b_hold <= result;
                else         a_hold <= result;
            end
        end
    end

endmodule
